// File: rtl/interface_serial_coprocessador.sv
// Streaming front-end for the combinational matrix coprocessor: assembles operand
// buses from a valid/ready word stream and returns result elements plus det as a stream.
//
// state    | meaning
// IDLE     | one cycle after reset, nothing accepted
// HEADER   | waiting for the operation word
// LOAD_A   | loading N*N elements of A, row-major
// LOAD_B   | loading N*N elements of B, row-major
// LOAD_ESC | waiting for the scalar
// EXEC     | operands stable, result and det captured on the closing edge
// SEND     | streaming N*N result elements then det (out_last)
module interface_serial_coprocessador #(
  parameter int N     = 3,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3*WIDTH:0]           out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic [2:0]                 cp_operacao,
  output logic [WIDTH-1:0]           cp_escalar,
  output logic [N*N*WIDTH-1:0]       cp_A,
  output logic [N*N*WIDTH-1:0]       cp_B,
  input  logic [N*N*(2*WIDTH+3)-1:0] cp_resultado,
  input  logic [3*WIDTH:0]           cp_det
);

  localparam int RW = 2*WIDTH+3;
  localparam int DW = 3*WIDTH+1;
  localparam int NN = N*N;
  localparam int IW = $clog2(NN+1);
  localparam logic [IW-1:0] LAST_EL = IW'(NN-1);
  localparam logic [IW-1:0] DET_IDX = IW'(NN);
  localparam logic [IW-1:0] ONE     = IW'(1);

  typedef enum logic [2:0] {IDLE, HEADER, LOAD_A, LOAD_B, LOAD_ESC, EXEC, SEND} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx;
  logic [DW-1:0] res_buf [NN];
  logic [DW-1:0] det_buf;
  logic          in_acc, out_acc;

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE:   state_next = HEADER;
      HEADER: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && idx == LAST_EL) state_next = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && idx == LAST_EL) state_next = LOAD_ESC;
      end
      LOAD_ESC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC: begin
        busy       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (idx == DET_IDX);
        if (out_ready && idx == DET_IDX) state_next = HEADER;
      end
      default: state_next = IDLE;
    endcase
  end

  // idx doubles as the response word pointer in SEND, where it reaches N*N for det
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     idx <= '0;
    else if (state_next != state)   idx <= '0;
    else if (in_acc || out_acc)     idx <= idx + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cp_operacao <= '0;
      cp_escalar  <= '0;
      cp_A        <= '0;
      cp_B        <= '0;
      det_buf     <= '0;
      for (int i = 0; i < NN; i++) res_buf[i] <= '0;
    end else begin
      if (in_acc) begin
        case (state)
          HEADER:   cp_operacao <= in_data[2:0];
          LOAD_A: begin
            for (int i = 0; i < NN; i++)
              if (idx == IW'(i)) cp_A[(NN-1-i)*WIDTH +: WIDTH] <= in_data;
          end
          LOAD_B: begin
            for (int i = 0; i < NN; i++)
              if (idx == IW'(i)) cp_B[(NN-1-i)*WIDTH +: WIDTH] <= in_data;
          end
          LOAD_ESC: cp_escalar <= in_data;
          default: ;
        endcase
      end
      if (state == EXEC) begin
        for (int i = 0; i < NN; i++)
          res_buf[i] <= {{(DW-RW){cp_resultado[(NN-1-i)*RW + RW-1]}},
                         cp_resultado[(NN-1-i)*RW +: RW]};
        det_buf <= cp_det;
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (state == SEND) begin
      if (idx == DET_IDX) out_data = det_buf;
      for (int i = 0; i < NN; i++)
        if (idx == IW'(i)) out_data = res_buf[i];
    end
  end

endmodule

// File: tb/tb_interface_serial_coprocessador.sv
// Bench for interface_serial_coprocessador: table frames, forced-result corners,
// reset cases and random frames checked against a frame-level reference model.
module tb_interface_serial_coprocessador;
  localparam int NN = 9;
  localparam int RW = 19;
  localparam int FW = 2*NN+2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0]    in_data, cp_escalar;
  logic [24:0]   out_data, cp_det;
  logic [2:0]    cp_operacao;
  logic [71:0]   cp_A, cp_B;
  logic [170:0]  cp_resultado;

  logic          force_res, force_det;
  logic [170:0]  forced_res;
  logic [24:0]   forced_det;

  int checks = 0;
  int errors = 0;

  logic [7:0]    frame [FW];
  logic [24:0]   exp_words [NN+1];
  logic [71:0]   exp_a, exp_b;
  logic [2:0]    exp_op;
  logic [7:0]    exp_esc;

  typedef struct packed {
    logic [2:0]        op;
    logic [8:0][7:0]   a;
    logic [8:0][7:0]   b;
    logic [7:0]        esc;
    logic [24:0]       det;
    logic [1:0]        gap;
    logic [1:0]        bp;
    logic [9:0][24:0]  expw;
  } vec_t;
  vec_t vecs [3];

  always #5 clk = ~clk;

  interface_serial_coprocessador #(.N(3), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .cp_operacao(cp_operacao), .cp_escalar(cp_escalar),
    .cp_A(cp_A), .cp_B(cp_B), .cp_resultado(cp_resultado), .cp_det(cp_det)
  );

  // Stand-in coprocessor: op 2 is a matrix product, other ops an element-wise mix
  function automatic logic [170:0] copro_res(input logic [2:0] op, input logic [71:0] a,
                                             input logic [71:0] b, input logic [7:0] esc);
    int av [9];
    int bv [9];
    int r;
    logic [170:0] res;
    res = '0;
    for (int i = 0; i < 9; i++) begin
      av[i] = int'($signed(a[(8-i)*8 +: 8]));
      bv[i] = int'($signed(b[(8-i)*8 +: 8]));
    end
    for (int i = 0; i < 9; i++) begin
      r = 0;
      if (op == 3'd2) begin
        for (int k = 0; k < 3; k++) r = r + av[(i/3)*3+k] * bv[k*3+(i%3)];
      end else begin
        r = av[i] * bv[i] + int'($signed(esc)) + int'(op);
      end
      res[(8-i)*RW +: RW] = r[18:0];
    end
    return res;
  endfunction

  function automatic logic [24:0] copro_det(input logic [71:0] a, input logic [7:0] esc);
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) s = s + int'($signed(a[(8-i)*8 +: 8]));
    s = s - int'($signed(esc));
    return s[24:0];
  endfunction

  assign cp_resultado = force_res ? forced_res : copro_res(cp_operacao, cp_A, cp_B, cp_escalar);
  assign cp_det       = force_det ? forced_det : copro_det(cp_A, cp_escalar);

  task automatic check(input string name, input logic [170:0] act, input logic [170:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Expected operand buses and response words derived from the frame words alone
  task automatic build_model();
    logic [170:0] res;
    int v;
    exp_op  = frame[0][2:0];
    exp_esc = frame[FW-1];
    for (int i = 0; i < NN; i++) begin
      exp_a[(NN-1-i)*8 +: 8] = frame[1+i];
      exp_b[(NN-1-i)*8 +: 8] = frame[1+NN+i];
    end
    res = force_res ? forced_res : copro_res(exp_op, exp_a, exp_b, exp_esc);
    for (int i = 0; i < NN; i++) begin
      v = int'($signed(res[(NN-1-i)*RW +: RW]));
      exp_words[i] = v[24:0];
    end
    exp_words[NN] = force_det ? forced_det : copro_det(exp_a, exp_esc);
  endtask

  // gap: 0 none, 1 toggle, 2 random. bp: 0 always ready, 1 hold 5 then toggle, 2 random
  task automatic run_frame(input int gap, input int bp);
    int wi, oi, cyc, sc_cyc, ov_cyc;
    logic pend, pl;
    logic [24:0] pd;
    wi = 0; oi = 0; cyc = 0; sc_cyc = -1; ov_cyc = -1; pend = 1'b0; pl = 1'b0; pd = '0;
    while (oi <= NN && cyc < 400) begin
      @(negedge clk);
      in_valid = (wi < FW) && (gap == 0 || (gap == 1 && cyc % 2 == 1) ||
                               (gap == 2 && $urandom_range(0, 2) != 0));
      in_data  = (wi < FW && in_valid) ? frame[wi] : 8'($urandom);
      if (out_valid && ov_cyc < 0) begin
        ov_cyc = cyc;
        check("latency", 171'(cyc - sc_cyc), 171'(2));
      end
      if (bp == 0)      out_ready = 1'b1;
      else if (bp == 1) out_ready = (ov_cyc >= 0) && (cyc - ov_cyc >= 5) && ((cyc - ov_cyc) % 2 == 1);
      else              out_ready = 1'($urandom_range(0, 1));
      if (sc_cyc >= 0 && cyc == sc_cyc + 1) begin
        check("exec_op", cp_operacao, exp_op);
        check("exec_esc", cp_escalar, exp_esc);
        check("exec_A", cp_A, exp_a);
        check("exec_B", cp_B, exp_b);
        check("exec_busy", busy, 1'b1);
        check("exec_out_valid", out_valid, 1'b0);
      end
      if (sc_cyc >= 0 && cyc > sc_cyc) check("resp_in_ready", in_ready, 1'b0);
      if (pend) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, pd);
        check("hold_last", out_last, pl);
      end
      if (out_valid && out_ready) begin
        check($sformatf("word%0d", oi), out_data, exp_words[oi]);
        check($sformatf("last%0d", oi), out_last, (oi == NN));
        oi++;
      end
      pend = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      if (in_valid && in_ready) begin
        if (wi == FW-1) sc_cyc = cyc;
        wi++;
      end
      cyc++;
    end
    check("frame_complete", 171'(oi), 171'(NN+1));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("next_in_ready", in_ready, 1'b1);
    check("next_busy", busy, 1'b0);
  endtask

  task automatic load_vec(input int k);
    frame[0] = {5'($urandom), vecs[k].op};
    for (int i = 0; i < NN; i++) begin
      frame[1+i]    = vecs[k].a[i];
      frame[1+NN+i] = vecs[k].b[i];
    end
    frame[FW-1] = vecs[k].esc;
    force_res  = 1'b0;
    force_det  = 1'b1;
    forced_det = vecs[k].det;
    build_model();
    for (int i = 0; i <= NN; i++) exp_words[i] = vecs[k].expw[i];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mul_exp [10] = '{30, 24, 18, 84, 69, 54, 138, 114, 90, -3};
    int sent, cnt;

    for (int k = 0; k < 3; k++) begin
      vecs[k].op = 3'd2;
      vecs[k].gap = 2'd0;
      vecs[k].bp = 2'd0;
      for (int i = 0; i < NN; i++) begin
        vecs[k].a[i] = (k == 2) ? ((i % 4 == 0) ? 8'd1 : 8'd0) : 8'(i+1);
        vecs[k].b[i] = (k == 2) ? 8'(-(i+1)) : 8'(9-i);
      end
      vecs[k].esc = (k == 2) ? 8'h80 : 8'd2;
      vecs[k].det = (k == 2) ? 25'd5 : 25'h1FFFFFD;
      for (int i = 0; i <= NN; i++)
        vecs[k].expw[i] = (k == 2) ? ((i == NN) ? 25'd5 : 25'(-(i+1))) : 25'(mul_exp[i]);
    end
    vecs[1].gap = 2'd1;
    vecs[2].bp  = 2'd1;

    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h05; out_ready = 1'b1;
    force_res = 1'b0; force_det = 1'b0; forced_res = '0; forced_det = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 25'd0);
    check("rst_cp_op", cp_operacao, 3'd0);
    check("rst_cp_esc", cp_escalar, 8'd0);
    check("rst_cp_A", cp_A, 72'd0);
    check("rst_cp_B", cp_B, 72'd0);
    rst_n = 1'b1;
    #1 check("release_in_ready_low", in_ready, 1'b0);
    @(negedge clk);
    check("release_in_ready_high", in_ready, 1'b1);
    check("release_nothing_accepted", cp_operacao, 3'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;

    for (int k = 0; k < 3; k++) begin
      load_vec(k);
      run_frame(int'(vecs[k].gap), int'(vecs[k].bp));
    end

    frame[0] = 8'h01;
    for (int i = 1; i < FW; i++) frame[i] = 8'($urandom);
    force_res = 1'b1; force_det = 1'b0;
    forced_res = '0;
    forced_res[8*RW +: RW] = 19'h7FFFF;
    forced_res[0 +: RW]    = 19'h3FFFF;
    build_model();
    exp_words[0] = 25'h1FFFFFF;
    exp_words[8] = 25'h003FFFF;
    run_frame(0, 0);
    force_res = 1'b0;

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < FW; i++) frame[i] = 8'($urandom);
      build_model();
      run_frame(2, 2);
    end

    load_vec(0);
    sent = 0; cnt = 0;
    while (sent < 6 && cnt < 50) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = frame[sent];
      if (in_ready) sent++;
      cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("midframe_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_cp_A", cp_A, 72'd0);
    check("midrst_cp_op", cp_operacao, 3'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_vec(0);
    run_frame(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
